// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control encodings, default tag/data widths and
// the reservation-station entry layout.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1000;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic             valid;
    logic [3:0]       alu_ctrl;
    logic [TAG_W-1:0] dst_tag;
    rs_src_t          src1;
    rs_src_t          src2;
  } rs_entry_t;

endpackage

// File: rtl/rs_src_operand.sv
// Per-source CDB snoop: a waiting source whose tag matches a valid broadcast
// becomes ready and takes the broadcast value. Purely combinational.
module rs_src_operand #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_value_i,
  input  logic              rdy_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] val_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] val_o
);

  logic hit;

  assign hit   = !rdy_i && cdb_valid_i && (cdb_tag_i == tag_i);
  assign rdy_o = rdy_i || hit;
  assign val_o = hit ? cdb_value_i : val_i;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: collapsing age-ordered queue that captures CDB results
// and issues the oldest entry with both operands ready over valid/ready.
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = cpu_pkg::TAG_W,
  parameter int DATA_W      = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [3:0]        disp_alu_ctrl,
  input  logic [TAG_W-1:0]  disp_dst_tag,
  input  logic              disp_src1_rdy,
  input  logic [TAG_W-1:0]  disp_src1_tag,
  input  logic [DATA_W-1:0] disp_src1_val,
  input  logic              disp_src2_rdy,
  input  logic [TAG_W-1:0]  disp_src2_tag,
  input  logic [DATA_W-1:0] disp_src2_val,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [DATA_W-1:0] issue_a,
  output logic [DATA_W-1:0] issue_b,
  output logic [3:0]        issue_alu_ctrl,
  output logic [TAG_W-1:0]  issue_dst_tag
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  rs_entry_t        ent_q [NUM_ENTRIES];
  rs_entry_t        ent_d [NUM_ENTRIES];
  rs_entry_t        woken [NUM_ENTRIES];
  rs_entry_t        disp_ent;
  logic [CNT_W-1:0] count_q, count_d, cnt_after;

  logic              s1_rdy [NUM_ENTRIES];
  logic              s2_rdy [NUM_ENTRIES];
  logic [DATA_W-1:0] s1_val [NUM_ENTRIES];
  logic [DATA_W-1:0] s2_val [NUM_ENTRIES];
  logic              d1_rdy, d2_rdy;
  logic [DATA_W-1:0] d1_val, d2_val;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_fire, disp_fire;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_wake
    rs_src_operand #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_src1 (
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
      .rdy_i(ent_q[g].src1.rdy), .tag_i(ent_q[g].src1.tag), .val_i(ent_q[g].src1.val),
      .rdy_o(s1_rdy[g]), .val_o(s1_val[g]));
    rs_src_operand #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_src2 (
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
      .rdy_i(ent_q[g].src2.rdy), .tag_i(ent_q[g].src2.tag), .val_i(ent_q[g].src2.val),
      .rdy_o(s2_rdy[g]), .val_o(s2_val[g]));
  end

  rs_src_operand #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_disp_src1 (
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
    .rdy_i(disp_src1_rdy), .tag_i(disp_src1_tag), .val_i(disp_src1_val),
    .rdy_o(d1_rdy), .val_o(d1_val));
  rs_src_operand #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_disp_src2 (
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
    .rdy_i(disp_src2_rdy), .tag_i(disp_src2_tag), .val_i(disp_src2_val),
    .rdy_o(d2_rdy), .val_o(d2_val));

  // Select looks only at registered state, so a CDB hit never reaches issue in the same cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_valid    = sel_found;
  assign issue_a        = sel_found ? ent_q[sel_idx].src1.val : '0;
  assign issue_b        = sel_found ? ent_q[sel_idx].src2.val : '0;
  assign issue_alu_ctrl = sel_found ? ent_q[sel_idx].alu_ctrl : '0;
  assign issue_dst_tag  = sel_found ? ent_q[sel_idx].dst_tag  : '0;

  assign disp_ready = (count_q < CNT_W'(NUM_ENTRIES)) && !flush;
  assign issue_fire = issue_valid && issue_ready;
  assign disp_fire  = disp_valid && disp_ready;

  always_comb begin
    disp_ent          = '0;
    disp_ent.valid    = 1'b1;
    disp_ent.alu_ctrl = disp_alu_ctrl;
    disp_ent.dst_tag  = disp_dst_tag;
    disp_ent.src1     = '{rdy: d1_rdy, tag: disp_src1_tag, val: d1_val};
    disp_ent.src2     = '{rdy: d2_rdy, tag: disp_src2_tag, val: d2_val};
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      woken[i]          = ent_q[i];
      woken[i].src1.rdy = s1_rdy[i];
      woken[i].src1.val = s1_val[i];
      woken[i].src2.rdy = s2_rdy[i];
      woken[i].src2.val = s2_val[i];
    end
  end

  // Collapse first, then append the dispatched op at the post-collapse tail.
  always_comb begin
    ent_d     = woken;
    cnt_after = count_q - CNT_W'(issue_fire);
    if (issue_fire) begin
      for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
        if (i >= int'(sel_idx)) ent_d[i] = woken[i+1];
      end
      ent_d[NUM_ENTRIES-1] = '0;
    end
    if (disp_fire) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (i == int'(cnt_after)) ent_d[i] = disp_ent;
      end
    end
    count_d = cnt_after + CNT_W'(disp_fire);
    if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_d[i].valid = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios followed by random traffic,
// all compared against a queue-based model of the station.
module tb_alu_reservation_station;

  localparam int N = 4;

  logic        clk, rst_n, flush;
  logic        disp_valid, disp_ready;
  logic [3:0]  disp_alu_ctrl;
  logic [5:0]  disp_dst_tag, disp_src1_tag, disp_src2_tag;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic [31:0] disp_src1_val, disp_src2_val;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_a, issue_b;
  logic [3:0]  issue_alu_ctrl;
  logic [5:0]  issue_dst_tag;

  alu_reservation_station #(.NUM_ENTRIES(N), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_alu_ctrl(disp_alu_ctrl), .disp_dst_tag(disp_dst_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_a(issue_a), .issue_b(issue_b),
    .issue_alu_ctrl(issue_alu_ctrl), .issue_dst_tag(issue_dst_tag));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [5:0]  dst;
    bit          r1;
    logic [5:0]  t1;
    logic [31:0] v1;
    bit          r2;
    logic [5:0]  t2;
    logic [31:0] v2;
  } op_t;

  op_t q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int oldest_ready();
    for (int i = 0; i < q.size(); i++)
      if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  // Compare outputs mid-cycle, then advance the model across the coming edge.
  task automatic cycle();
    int s;
    bit acc;
    op_t n;
    logic [31:0] ea, eb;
    logic [3:0]  ec;
    logic [5:0]  ed;
    @(negedge clk);
    s = oldest_ready();
    ea = '0; eb = '0; ec = '0; ed = '0;
    if (s >= 0) begin
      ea = q[s].v1; eb = q[s].v2; ec = q[s].ctrl; ed = q[s].dst;
    end
    chk("disp_ready", disp_ready, (q.size() < N) && !flush);
    chk("issue_valid", issue_valid, s >= 0);
    chk("issue_a", issue_a, ea);
    chk("issue_b", issue_b, eb);
    chk("issue_ctrl", issue_alu_ctrl, ec);
    chk("issue_dst", issue_dst_tag, ed);
    acc = disp_valid && (q.size() < N) && !flush;
    if (flush) q.delete();
    else begin
      if (s >= 0 && issue_ready) q.delete(s);
      foreach (q[i]) begin
        if (!q[i].r1 && cdb_valid && q[i].t1 == cdb_tag) begin q[i].r1 = 1; q[i].v1 = cdb_value; end
        if (!q[i].r2 && cdb_valid && q[i].t2 == cdb_tag) begin q[i].r2 = 1; q[i].v2 = cdb_value; end
      end
      if (acc) begin
        n = '{disp_alu_ctrl, disp_dst_tag, disp_src1_rdy, disp_src1_tag, disp_src1_val,
              disp_src2_rdy, disp_src2_tag, disp_src2_val};
        if (!n.r1 && cdb_valid && n.t1 == cdb_tag) begin n.r1 = 1; n.v1 = cdb_value; end
        if (!n.r2 && cdb_valid && n.t2 == cdb_tag) begin n.r2 = 1; n.v2 = cdb_value; end
        q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0;
    cdb_valid  = 0;
    flush      = 0;
    #1;
  endtask

  task automatic disp(input logic [3:0] c, input logic [5:0] d,
                      input bit r1, input logic [5:0] t1, input logic [31:0] v1,
                      input bit r2, input logic [5:0] t2, input logic [31:0] v2);
    disp_valid = 1; disp_alu_ctrl = c; disp_dst_tag = d;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
  endtask

  task automatic bcast(input logic [5:0] t, input logic [31:0] v);
    cdb_valid = 1; cdb_tag = t; cdb_value = v;
  endtask

  initial begin
    rst_n = 0; flush = 0; disp_valid = 0; cdb_valid = 0; issue_ready = 0;
    disp_alu_ctrl = 0; disp_dst_tag = 0; disp_src1_rdy = 0; disp_src1_tag = 0;
    disp_src1_val = 0; disp_src2_rdy = 0; disp_src2_tag = 0; disp_src2_val = 0;
    cdb_tag = 0; cdb_value = 0;
    #12;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_issue_a", issue_a, 0);
    chk("rst_issue_dst", issue_dst_tag, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // ADD with both operands ready: issuable next cycle, gone after it issues.
    issue_ready = 1;
    disp(4'b0010, 6'd3, 1, 6'd0, 32'd5, 1, 6'd0, 32'd7);
    cycle(); idle();
    chk("add_valid", issue_valid, 1);
    chk("add_a", issue_a, 32'd5);
    chk("add_b", issue_b, 32'd7);
    chk("add_ctrl", issue_alu_ctrl, 4'b0010);
    chk("add_dst", issue_dst_tag, 6'd3);
    cycle();
    chk("add_drained", issue_valid, 0);

    // SUB waiting on tag 9, broadcast two cycles later.
    disp(4'b0110, 6'd8, 0, 6'd9, 32'd0, 1, 6'd0, 32'd1);
    cycle(); idle();
    cycle();
    bcast(6'd9, 32'h100);
    chk("sub_wait", issue_valid, 0);
    cycle(); idle();
    chk("sub_woken", issue_valid, 1);
    chk("sub_a", issue_a, 32'h100);
    cycle();

    // Same-cycle bypass on dispatch.
    disp(4'b0010, 6'd5, 0, 6'd4, 32'd0, 1, 6'd0, 32'd2);
    bcast(6'd4, 32'hFFFF_FFF0);
    cycle(); idle();
    chk("bypass_valid", issue_valid, 1);
    chk("bypass_a", issue_a, 32'hFFFF_FFF0);
    cycle();

    // Fill: ops 0-2 wait, op 3 ready; ops 1 and 2 share a producer.
    issue_ready = 0;
    disp(4'b0001, 6'd20, 0, 6'd10, 0, 1, 0, 32'd1); cycle();
    disp(4'b0001, 6'd21, 0, 6'd11, 0, 1, 0, 32'd2); cycle();
    disp(4'b0001, 6'd22, 0, 6'd11, 0, 1, 0, 32'd3); cycle();
    disp(4'b0011, 6'd23, 1, 6'd0, 32'd9, 1, 0, 32'd4); cycle();
    idle();
    chk("full_disp_ready", disp_ready, 0);
    issue_ready = 1;
    chk("full_first_dst", issue_dst_tag, 6'd23);
    cycle();
    bcast(6'd11, 32'h77);
    cycle(); idle();
    chk("order_op1", issue_dst_tag, 6'd21);
    cycle();
    chk("order_op2", issue_dst_tag, 6'd22);
    cycle();
    bcast(6'd10, 32'h55);
    cycle(); idle();
    chk("order_op0", issue_dst_tag, 6'd20);
    cycle();

    // Backpressure: ready XOR held for three cycles.
    issue_ready = 0;
    disp(4'b0011, 6'd30, 1, 0, 32'hAA, 1, 0, 32'h55);
    cycle(); idle();
    for (int k = 0; k < 3; k++) begin
      chk("hold_dst", issue_dst_tag, 6'd30);
      chk("hold_a", issue_a, 32'hAA);
      cycle();
    end
    issue_ready = 1;
    chk("hold_release", issue_valid, 1);
    cycle();
    chk("hold_drained", issue_valid, 0);

    // Flush with three entries and a concurrent dispatch.
    issue_ready = 0;
    disp(4'b0111, 6'd40, 1, 0, 32'd1, 1, 0, 32'd2); cycle();
    disp(4'b0111, 6'd41, 0, 6'd15, 0, 1, 0, 32'd2); cycle();
    disp(4'b1000, 6'd42, 1, 0, 32'd3, 0, 6'd16, 0); cycle();
    disp(4'b0010, 6'd43, 1, 0, 32'd4, 1, 0, 32'd5);
    flush = 1;
    cycle(); idle();
    chk("flush_valid", issue_valid, 0);
    chk("flush_disp_ready", disp_ready, 1);
    cycle();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      disp_valid    = ($urandom_range(0, 2) != 0);
      disp_alu_ctrl = 4'($urandom_range(0, 15));
      disp_dst_tag  = 6'($urandom_range(0, 63));
      disp_src1_rdy = ($urandom_range(0, 2) == 0);
      disp_src1_tag = 6'($urandom_range(0, 7));
      disp_src1_val = $urandom;
      disp_src2_rdy = ($urandom_range(0, 1) == 0);
      disp_src2_tag = 6'($urandom_range(0, 7));
      disp_src2_val = $urandom;
      cdb_valid     = ($urandom_range(0, 1) == 0);
      cdb_tag       = 6'($urandom_range(0, 7));
      cdb_value     = $urandom;
      issue_ready   = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      cycle();
    end

    // Asynchronous reset in the middle of traffic.
    idle();
    issue_ready = 0;
    disp(4'b0010, 6'd50, 1, 0, 32'd11, 1, 0, 32'd12);
    cycle(); idle();
    #2;
    rst_n = 0;
    #1;
    q.delete();
    chk("arst_valid", issue_valid, 0);
    chk("arst_a", issue_a, 0);
    chk("arst_dst", issue_dst_tag, 0);
    chk("arst_disp_ready", disp_ready, 1);
    #3;
    rst_n = 1;
    @(posedge clk); #1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
